yarp_mp_regfile: RTL
====================

# yarp_mp_regfile

Parametrised multi-port integer register file for the yarp core family. It provides NUM_RD combinational read ports and NUM_WR write ports, with optional same-cycle write-to-read bypass and a per-register busy scoreboard. Busy bits are set when a destination is allocated at issue and cleared by its writeback. It sits between decode/issue (reads, allocation) and the writeback stage(s), so dual-issue and multi-writeback pipelines can share one storage block.

## Interface
Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, register count (≥2); localparam ADDR_W = $clog2(NUM_REGS).
- NUM_RD, 2, number of read ports (≥1).
- NUM_WR, 2, number of write ports (≥1).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see registered state only.
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy.

Ports (vectors packed, port k occupies slice [k*W +: W]):
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses.
- rd_data_o  out  NUM_RD*DATA_W  read data.
- rd_busy_o  out  NUM_RD  addressed register has an outstanding allocation.
- wr_en_i  in  NUM_WR  per-port write enable.
- wr_addr_i  in  NUM_WR*ADDR_W  write addresses.
- wr_data_i  in  NUM_WR*DATA_W  write data.
- alloc_en_i  in  1  mark alloc_addr_i busy.
- alloc_addr_i  in  ADDR_W  register to allocate.
- flush_i  in  1  clear all busy bits.

## Operation
- Storage: regs_q[NUM_REGS][DATA_W], busy_q[NUM_REGS]. On reset, all regs_q and busy_q are 0.
- Write: at the clock edge, regs_q[wr_addr[k]] <= wr_data[k] for each k with wr_en[k]=1.
- Write conflict: when several enabled ports target the same address, the highest-indexed port wins. The other ports' data is discarded.
- ZERO_REG=1:
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0, including under bypass.
  - alloc of address 0 is ignored; rd_busy is 0 for address 0.
- Addresses ≥ NUM_REGS (non-power-of-2 depth):
  - Writes and allocs are ignored.
  - Reads return 0 with busy 0.
- Read, BYPASS=0: rd_data[j] = regs_q[rd_addr[j]] and rd_busy[j] = busy_q[rd_addr[j]].
- Read, BYPASS=1, when an enabled write port targets rd_addr[j] this cycle:
  - rd_data[j] = data of the winning write port, per the conflict rule above.
  - rd_busy[j] = 0, unless alloc_en_i targets the same address this cycle.
- Read, BYPASS=1, no matching write: same as BYPASS=0.
- Busy update at each edge, in priority order:
  1. flush_i=1: all busy_q <= 0, except that an alloc in the same cycle still sets its bit (the new allocation is younger than the flush).
  2. alloc_en_i=1: busy_q[alloc_addr] <= 1.
  3. Any enabled write to r: busy_q[r] <= 0.
- Alloc and write to the same register in the same cycle: alloc wins, so the bit ends at 1.
- Multiple allocs per cycle are not supported. Re-alloc of an already-busy register is legal; the bit stays 1.

## Timing
- Reads are purely combinational from rd_addr_i, regs_q, busy_q and (BYPASS=1) wr_*/alloc_*. There is no read latency.
- A write becomes visible in regs_q one cycle after wr_en. With BYPASS=1 it is also visible in the same cycle.
- Alloc takes effect on rd_busy_o the cycle after alloc_en_i, or the same cycle under the BYPASS alloc-override rule above.
- Reset asserted mid-operation immediately forces regs_q=0 and busy_q=0, so rd_data_o=0 and rd_busy_o=0 for every address.
- Writes and allocs presented while reset_n=0 are lost.
- First writes are accepted at the first rising edge after reset_n deasserts.
- Critical path (BYPASS=1): address compare across NUM_WR ports, then priority select, then read mux. No combinational loops.

## Test plan
- Reset, then read all addresses on every port: rd_data=0 and rd_busy=0. Repeat with reset asserted mid-stream after writes: values return to 0 asynchronously.
- Write x5=0xDEADBEEF on port 0; read x5 on both ports next cycle: 0xDEADBEEF. Write x0=0x1234: read x0 = 0.
- Same-cycle write x7: port0=0x11, port1=0x22. With BYPASS=1 the same-cycle read returns 0x22, and the next cycle returns 0x22. With BYPASS=0 the same-cycle read returns the old value and the next cycle returns 0x22.
- Busy flow:
  - alloc x9 → next cycle rd_busy=1.
  - Write x9 → BYPASS=1 same-cycle busy=0; next cycle busy=0.
  - alloc x9 plus write x9 in the same cycle → busy stays 1.
- flush_i with x3, x4 busy and a simultaneous alloc x6: next cycle x3=0, x4=0, x6=1.
- Parameter sweep (DATA_W=64, NUM_REGS=24, NUM_RD=3, NUM_WR=1, ZERO_REG=0): x0 is writable and allocable; reads of addresses 24–31 return 0; a random write/read/alloc run matches a reference model.

Source files
------------

// File: rtl/yarp_mp_regfile.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | yarp_mp_regfile: multi-port register file with write bypass and busy    |
// | scoreboard.  Rev 1.0                                                    |
// +------------------------------------------------------------------------+
module yarp_mp_regfile #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 2,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_busy_o,
    input  logic [NUM_WR-1:0]          wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data_i,
    input  logic                       alloc_en_i,
    input  logic [ADDR_W-1:0]          alloc_addr_i,
    input  logic                       flush_i
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic [NUM_REGS-1:0] w_we;
    logic [NUM_REGS-1:0] w_alloc;
    logic [DATA_W-1:0]   w_wdata [NUM_REGS];

    // Per-register decode; later write ports overwrite earlier ones so the
    // highest-indexed port wins. Out-of-range addresses never match any r.
    always_comb begin
        w_we    = '0;
        w_alloc = '0;
        busy_d  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_wdata[r] = '0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en_i[k] && (wr_addr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    w_we[r]    = 1'b1;
                    w_wdata[r] = wr_data_i[k*DATA_W +: DATA_W];
                end
            end
            if (alloc_en_i && (alloc_addr_i == ADDR_W'(r))) begin
                w_alloc[r] = 1'b1;
            end
            if ((ZERO_REG != 0) && (r == 0)) begin
                w_we[r]    = 1'b0;
                w_alloc[r] = 1'b0;
            end
            // Alloc is younger than both the flush and any writeback.
            busy_d[r] = w_alloc[r] | (~flush_i & ~w_we[r] & busy_q[r]);
            regs_d[r] = w_we[r] ? w_wdata[r] : regs_q[r];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    // A bypassed read reports busy only if the same register is re-allocated
    // this cycle; register 0 under ZERO_REG is never written so reads stay 0.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rd_addr_i[j*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    if ((BYPASS != 0) && w_we[r]) begin
                        rd_data_o[j*DATA_W +: DATA_W] = w_wdata[r];
                        rd_busy_o[j]                  = w_alloc[r];
                    end else begin
                        rd_data_o[j*DATA_W +: DATA_W] = regs_q[r];
                        rd_busy_o[j]                  = busy_q[r];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
